// File: rtl/vram_dma_if.sv
// Z80 / CRTC / main-RAM signal bundle seen by the VRAM DMA arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface vram_dma_if;
  localparam int unsigned ADR_W  = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              crtc_busreq;
  logic              crtc_busack;
  logic [ADR_W-1:0]  crtc_adr;
  logic [DATA_W-1:0] crtc_data;
  logic              cpu_busrq_n;
  logic              cpu_busak_n;
  logic [ADR_W-1:0]  cpu_adr;
  logic              cpu_we;
  logic [ADR_W-1:0]  ram_adr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic              vsync;
  logic [CNT_W-1:0]  stall_cnt;
  logic              dma_err;
  logic              err_clr;

  modport slave (
    input  crtc_busreq, crtc_adr, cpu_busak_n, cpu_adr, cpu_we, ram_din, vsync, err_clr,
    output crtc_busack, crtc_data, cpu_busrq_n, ram_adr, ram_we, stall_cnt, dma_err
  );

  modport master (
    output crtc_busreq, crtc_adr, cpu_busak_n, cpu_adr, cpu_we, ram_din, vsync, err_clr,
    input  crtc_busack, crtc_data, cpu_busrq_n, ram_adr, ram_we, stall_cnt, dma_err
  );
endinterface

// File: rtl/vram_dma_arbiter.sv
// Arbitrates main RAM between the Z80 and the CRTC row-buffer DMA via BUSRQ/BUSAK,
// enforces a CPU window after each burst and tracks per-frame DMA-stolen cycles.
module vram_dma_arbiter #(
  parameter int unsigned HOLDOFF = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  vram_dma_if.slave  bus
);
  localparam int unsigned HO_W  = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [HO_W-1:0]  HOLDOFF_V = HO_W'(HOLDOFF);
  localparam logic [CNT_W-1:0] TCNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GCNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t            state, state_nxt;
  logic              busrq_n_q, busack_q;
  logic              busrq_n_nxt, busack_nxt;
  logic [HO_W-1:0]   holdoff;
  logic [CNT_W-1:0]  tcnt;
  logic [CNT_W-1:0]  gcnt;
  logic [CNT_W-1:0]  stall_q;
  logic              err_q;
  logic              vsync_d;
  logic              vsync_rise;

  // State register; handshake outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busrq_n_q <= 1'b1;
      busack_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      busrq_n_q <= busrq_n_nxt;
      busack_q  <= busack_nxt;
    end
  end

  // Next state; an abort in REQ takes priority over a same-cycle BUSAK.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.crtc_busreq && (holdoff == '0)) state_nxt = REQ;
      REQ:     if (!bus.crtc_busreq)                   state_nxt = IDLE;
               else if (!bus.cpu_busak_n)              state_nxt = GRANT;
      GRANT:   if (!bus.crtc_busreq)                   state_nxt = RELEASE;
      RELEASE: if (bus.cpu_busak_n)                    state_nxt = IDLE;
      default:                                         state_nxt = IDLE;
    endcase
  end

  // Output decode of the next state.
  always_comb begin
    busrq_n_nxt = 1'b1;
    busack_nxt  = 1'b0;
    case (state_nxt)
      REQ:     busrq_n_nxt = 1'b0;
      GRANT: begin
        busrq_n_nxt = 1'b0;
        busack_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Hold-off only counts down in IDLE, so the CPU window after a burst is
  // HOLDOFF+1 cycles however long the Z80 takes to drop BUSAK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff <= '0;
    end else if ((state == GRANT) && (state_nxt == RELEASE)) begin
      holdoff <= HOLDOFF_V;
    end else if ((state == IDLE) && (holdoff != '0)) begin
      holdoff <= holdoff - HO_W'(1);
    end
  end

  // BUSAK timeout; the error is sticky and a same-cycle set beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state != REQ) && (state_nxt == REQ)) begin
        tcnt <= '0;
      end else if ((state == REQ) && (tcnt != TCNT_MAX)) begin
        tcnt <= tcnt + CNT_W'(1);
      end
      if ((state == REQ) && (tcnt == TCNT_MAX)) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign vsync_rise = bus.vsync && !vsync_d;

  // Granted-cycle statistics; a granted vsync-edge cycle belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      gcnt    <= '0;
      stall_q <= '0;
    end else begin
      vsync_d <= bus.vsync;
      if (vsync_rise) begin
        stall_q <= gcnt;
        gcnt    <= busack_q ? CNT_W'(1) : '0;
      end else if (busack_q && (gcnt != GCNT_MAX)) begin
        gcnt <= gcnt + CNT_W'(1);
      end
    end
  end

  assign bus.crtc_busack = busack_q;
  assign bus.cpu_busrq_n = busrq_n_q;
  assign bus.ram_adr     = busack_q ? bus.crtc_adr : bus.cpu_adr;
  assign bus.ram_we      = bus.cpu_we & ~busack_q;
  assign bus.crtc_data   = bus.ram_din;
  assign bus.stall_cnt   = stall_q;
  assign bus.dma_err     = err_q;
endmodule

// File: tb/tb_vram_dma_arbiter.sv
// Self-checking bench for vram_dma_arbiter: scripted and randomized bursts against
// a frame-level model of granted cycles, hold-off windows and the BUSAK timeout.
module tb_vram_dma_arbiter;
  localparam int unsigned HOLDOFF = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  vram_dma_if bus ();

  vram_dma_arbiter #(.HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  // Frame model: granted cycles since the last vsync rising edge (edge cycle included).
  int frame_cnt;
  int exp_stall;
  bit vs_prev;

  // Close the current cycle; 'granted' is whether the bench expects a grant in it.
  task automatic tick(input bit granted);
    bit rise;
    rise = (bus.vsync === 1'b1) && !vs_prev;
    if (rise) begin
      exp_stall = frame_cnt;
      frame_cnt = granted ? 1 : 0;
    end else if (granted && frame_cnt < 65535) begin
      frame_cnt++;
    end
    vs_prev = bus.vsync;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    frame_cnt = 0;
    exp_stall = 0;
    vs_prev   = 1'b0;
  endtask

  task automatic drive_rand();
    bus.cpu_adr  = 17'($urandom);
    bus.crtc_adr = 17'($urandom);
    bus.ram_din  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive_rand();
    bus.cpu_we = 1'b1;
    #1;
    n_tests++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL reset_busrq_n got %b want 1", bus.cpu_busrq_n); end
    n_tests++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL reset_busack got %b want 0", bus.crtc_busack); end
    n_tests++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
    n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.dma_err); end
    n_tests++; if (bus.ram_adr !== bus.cpu_adr) begin n_fail++; $display("FAIL reset_ram_adr got %h want %h", bus.ram_adr, bus.cpu_adr); end
    n_tests++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL reset_ram_we got %b want 1", bus.ram_we); end
    n_tests++; if (bus.crtc_data !== bus.ram_din) begin n_fail++; $display("FAIL reset_crtc_data got %h want %h", bus.crtc_data, bus.ram_din); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL idle_busrq_n got %b want 1", bus.cpu_busrq_n); end
      tick(1'b0);
    end
  endtask

  // busreq at cycle 10, BUSAK at 13, busreq drop at 253: grant 14..253, release at 254.
  task automatic test_basic_burst();
    bus.crtc_busreq = 1'b1;
    bus.cpu_we      = 1'b1;
    tick(1'b0);
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL basic_req_busrq_n got %b want 0", bus.cpu_busrq_n); end
      n_tests++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL basic_req_busack got %b want 0", bus.crtc_busack); end
      tick(1'b0);
    end
    bus.cpu_busak_n = 1'b0;
    n_tests++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_cycle_busack got %b want 0", bus.crtc_busack); end
    tick(1'b0);
    for (int i = 0; i < 240; i++) begin
      drive_rand();
      if (i == 239) bus.crtc_busreq = 1'b0;
      #1;
      n_tests++; if (bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL basic_grant_busack cyc %0d got %b want 1", 14 + i, bus.crtc_busack); end
      n_tests++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL basic_grant_busrq_n cyc %0d got %b want 0", 14 + i, bus.cpu_busrq_n); end
      n_tests++; if (bus.ram_adr !== bus.crtc_adr) begin n_fail++; $display("FAIL basic_grant_ram_adr cyc %0d got %h want %h", 14 + i, bus.ram_adr, bus.crtc_adr); end
      n_tests++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL basic_write_block cyc %0d got %b want 0", 14 + i, bus.ram_we); end
      n_tests++; if (bus.crtc_data !== bus.ram_din) begin n_fail++; $display("FAIL basic_crtc_data got %h want %h", bus.crtc_data, bus.ram_din); end
      tick(1'b1);
    end
    #1;
    n_tests++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL basic_release_busack got %b want 0", bus.crtc_busack); end
    n_tests++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL basic_release_busrq_n got %b want 1", bus.cpu_busrq_n); end
    n_tests++; if (bus.ram_adr !== bus.cpu_adr) begin n_fail++; $display("FAIL basic_release_ram_adr got %h want %h", bus.ram_adr, bus.cpu_adr); end
    n_tests++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL basic_release_ram_we got %b want 1", bus.ram_we); end
    bus.cpu_busak_n = 1'b1;
    tick(1'b0);
    repeat (HOLDOFF + 2) tick(1'b0);
    n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL basic_no_err got %b want 0", bus.dma_err); end
  endtask

  task automatic test_stats();
    int g1;
    int g2;
    bus.vsync = 1'b1;
    tick(1'b0);
    bus.vsync = 1'b0;
    n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL stats_frame1 got %0d want %0d", bus.stall_cnt, exp_stall); end
    tick(1'b0);
    // Second frame: vsync edge lands on a granted cycle.
    g1 = $urandom_range(10, 3);
    g2 = $urandom_range(12, 2);
    bus.crtc_busreq = 1'b1;
    tick(1'b0);
    bus.cpu_busak_n = 1'b0;
    tick(1'b0);
    for (int i = 0; i <= g1 + g2; i++) begin
      bus.vsync = (i == g1);
      if (i == g1 + g2) bus.crtc_busreq = 1'b0;
      #1;
      n_tests++; if (bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL stats_grant got %b want 1", bus.crtc_busack); end
      tick(1'b1);
      if (i == g1) begin
        n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL stats_coincident_edge got %0d want %0d", bus.stall_cnt, exp_stall); end
      end
    end
    bus.vsync = 1'b0;
    bus.cpu_busak_n = 1'b1;
    tick(1'b0);
    repeat (HOLDOFF + 2) tick(1'b0);
    bus.vsync = 1'b1;
    tick(1'b0);
    bus.vsync = 1'b0;
    n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL stats_frame_after_coincident got %0d want %0d", bus.stall_cnt, exp_stall); end
    tick(1'b0);
  endtask

  task automatic test_holdoff();
    for (int it = 0; it < 3; it++) begin
      int len;
      int rd;
      len = $urandom_range(8, 1);
      rd  = (it == 0) ? 1 : $urandom_range(2, 0);
      bus.crtc_busreq = 1'b1;
      tick(1'b0);
      bus.cpu_busak_n = 1'b0;
      tick(1'b0);
      for (int i = 0; i < len; i++) begin
        if (i == len - 1) bus.crtc_busreq = 1'b0;
        tick(1'b1);
      end
      bus.crtc_busreq = 1'b1;
      for (int j = 0; j < rd; j++) begin
        n_tests++; if (bus.cpu_busrq_n !== 1'b1 || bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL holdoff_release rq_n=%b ack=%b want 1/0", bus.cpu_busrq_n, bus.crtc_busack); end
        tick(1'b0);
      end
      bus.cpu_busak_n = 1'b1;
      tick(1'b0);
      for (int c = 0; c <= HOLDOFF; c++) begin
        n_tests++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL holdoff_gap idle cyc %0d got %b want 1", c, bus.cpu_busrq_n); end
        tick(1'b0);
      end
      n_tests++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL holdoff_fall idle cyc %0d got %b want 0", HOLDOFF + 1, bus.cpu_busrq_n); end
      bus.crtc_busreq = 1'b0;
      tick(1'b0);
      tick(1'b0);
    end
  endtask

  task automatic test_abort();
    int w;
    w = $urandom_range(3, 0);
    bus.crtc_busreq = 1'b1;
    tick(1'b0);
    for (int i = 0; i <= w; i++) begin
      n_tests++; if (bus.cpu_busrq_n !== 1'b0 || bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL abort_req rq_n=%b ack=%b want 0/0", bus.cpu_busrq_n, bus.crtc_busack); end
      tick(1'b0);
    end
    bus.crtc_busreq = 1'b0;
    tick(1'b0);
    n_tests++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL abort_busrq_n got %b want 1", bus.cpu_busrq_n); end
    n_tests++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL abort_busack got %b want 0", bus.crtc_busack); end
    bus.crtc_busreq = 1'b1;
    tick(1'b0);
    n_tests++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL abort_no_holdoff got %b want 0", bus.cpu_busrq_n); end
    bus.crtc_busreq = 1'b0;
    tick(1'b0);
    n_tests++; if (bus.cpu_busrq_n !== 1'b1 || bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL abort_again rq_n=%b ack=%b want 1/0", bus.cpu_busrq_n, bus.crtc_busack); end
    n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL abort_no_err got %b want 0", bus.dma_err); end
  endtask

  task automatic test_timeout();
    bus.err_clr = 1'b0;
    bus.crtc_busreq = 1'b1;
    tick(1'b0);
    for (int c = 0; c < TIMEOUT; c++) begin
      n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early cyc %0d after REQ got %b want 0", c, bus.dma_err); end
      tick(1'b0);
    end
    n_tests++; if (bus.dma_err !== 1'b1) begin n_fail++; $display("FAIL timeout_set got %b want 1", bus.dma_err); end
    n_tests++; if (bus.cpu_busrq_n !== 1'b0 || bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL timeout_still_req rq_n=%b ack=%b want 0/0", bus.cpu_busrq_n, bus.crtc_busack); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      n_tests++; if (bus.dma_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", bus.dma_err); end
    end
    bus.err_clr = 1'b1;
    tick(1'b0);
    bus.err_clr = 1'b0;
    n_tests++; if (bus.dma_err !== 1'b1) begin n_fail++; $display("FAIL timeout_set_wins got %b want 1", bus.dma_err); end
    bus.crtc_busreq = 1'b0;
    tick(1'b0);
    n_tests++; if (bus.dma_err !== 1'b1 || bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL timeout_abort err=%b rq_n=%b want 1/1", bus.dma_err, bus.cpu_busrq_n); end
    bus.err_clr = 1'b1;
    tick(1'b0);
    bus.err_clr = 1'b0;
    n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b want 0", bus.dma_err); end
    tick(1'b0);
    n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL timeout_stay_clear got %b want 0", bus.dma_err); end
  endtask

  task automatic test_random_bursts();
    for (int it = 0; it < 10; it++) begin
      int d;
      int len;
      int rd;
      int vpos;
      repeat ($urandom_range(3, 0)) tick(1'b0);
      if ($urandom_range(2, 0) == 0) begin
        bus.vsync = 1'b1;
        tick(1'b0);
        bus.vsync = 1'b0;
        n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL rand_idle_stall got %0d want %0d", bus.stall_cnt, exp_stall); end
      end
      d    = $urandom_range(3, 0);
      len  = $urandom_range(30, 1);
      rd   = $urandom_range(2, 0);
      vpos = $urandom_range(40, 0);
      bus.crtc_busreq = 1'b1;
      tick(1'b0);
      for (int i = 0; i < d; i++) begin
        n_tests++; if (bus.cpu_busrq_n !== 1'b0 || bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL rand_req rq_n=%b ack=%b want 0/0", bus.cpu_busrq_n, bus.crtc_busack); end
        tick(1'b0);
      end
      bus.cpu_busak_n = 1'b0;
      tick(1'b0);
      for (int i = 0; i < len; i++) begin
        drive_rand();
        bus.cpu_we = 1'($urandom);
        bus.vsync  = (i == vpos);
        if (i == len - 1) bus.crtc_busreq = 1'b0;
        #1;
        n_tests++; if (bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL rand_grant got %b want 1", bus.crtc_busack); end
        n_tests++; if (bus.ram_adr !== bus.crtc_adr || bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rand_mux adr=%h we=%b want %h/0", bus.ram_adr, bus.ram_we, bus.crtc_adr); end
        tick(1'b1);
        if (i == vpos) begin
          n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL rand_grant_stall got %0d want %0d", bus.stall_cnt, exp_stall); end
        end
      end
      bus.vsync = 1'b0;
      for (int j = 0; j < rd; j++) begin
        n_tests++; if (bus.cpu_busrq_n !== 1'b1 || bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL rand_release rq_n=%b ack=%b want 1/0", bus.cpu_busrq_n, bus.crtc_busack); end
        tick(1'b0);
      end
      bus.cpu_busak_n = 1'b1;
      #1;
      n_tests++; if (bus.ram_adr !== bus.cpu_adr || bus.ram_we !== bus.cpu_we) begin n_fail++; $display("FAIL rand_cpu_path adr=%h we=%b want %h/%b", bus.ram_adr, bus.ram_we, bus.cpu_adr, bus.cpu_we); end
      tick(1'b0);
      repeat (HOLDOFF + 1) tick(1'b0);
    end
  endtask

  task automatic test_reset_mid_burst();
    bus.crtc_busreq = 1'b1;
    tick(1'b0);
    repeat (TIMEOUT) tick(1'b0);
    bus.cpu_busak_n = 1'b0;
    tick(1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.vsync = (i == 5);
      tick(1'b1);
    end
    bus.vsync = 1'b0;
    n_tests++; if (bus.dma_err !== 1'b1 || bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL pre_reset err=%b ack=%b want 1/1", bus.dma_err, bus.crtc_busack); end
    n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL pre_reset_stall got %0d want %0d", bus.stall_cnt, exp_stall); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL async_reset_busack got %b want 0", bus.crtc_busack); end
    n_tests++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL async_reset_busrq_n got %b want 1", bus.cpu_busrq_n); end
    n_tests++; if (bus.stall_cnt !== 16'd0 || bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_regs stall=%0d err=%b want 0/0", bus.stall_cnt, bus.dma_err); end
    n_tests++; if (bus.ram_adr !== bus.cpu_adr) begin n_fail++; $display("FAIL async_reset_ram_adr got %h want %h", bus.ram_adr, bus.cpu_adr); end
    bus.crtc_busreq = 1'b0;
    bus.cpu_busak_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b0);
    bus.vsync = 1'b1;
    tick(1'b0);
    bus.vsync = 1'b0;
    n_tests++; if (bus.stall_cnt !== 16'(exp_stall)) begin n_fail++; $display("FAIL post_reset_gcnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    bus.crtc_busreq = 1'b1;
    tick(1'b0);
    n_tests++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_holdoff got %b want 0", bus.cpu_busrq_n); end
    repeat (TIMEOUT - 1) tick(1'b0);
    n_tests++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL post_reset_tcnt got %b want 0", bus.dma_err); end
    tick(1'b0);
    n_tests++; if (bus.dma_err !== 1'b1) begin n_fail++; $display("FAIL post_reset_timeout got %b want 1", bus.dma_err); end
    bus.crtc_busreq = 1'b0;
    tick(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst_n           = 1'b0;
    bus.crtc_busreq = 1'b0;
    bus.cpu_busak_n = 1'b1;
    bus.cpu_adr     = '0;
    bus.cpu_we      = 1'b0;
    bus.crtc_adr    = '0;
    bus.ram_din     = '0;
    bus.vsync       = 1'b0;
    bus.err_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_burst();
    test_stats();
    test_holdoff();
    test_abort();
    test_timeout();
    test_random_bursts();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
